// File: rtl/mac_pkg.sv
// mac_pkg: shared types and widths for the multiply-accumulate slice.
//   mac_state_t : accumulator FSM states (IDLE, ACCUM, HOLD)
//   OPND_W      : unsigned operand width (4)
//   PROD_W      : full product width (8)
package mac_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } mac_state_t;

endpackage

// File: rtl/multiplier_4bit.sv
// multiplier_4bit: combinational unsigned 4x4 -> 8-bit multiplier.
//   A : unsigned multiplicand
//   B : unsigned multiplier
//   P : full-width product A*B
module multiplier_4bit
    import mac_pkg::*;
(
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    output logic [PROD_W-1:0] P
);

    assign P = PROD_W'(A) * PROD_W'(B);

endmodule

// File: rtl/mac_accumulator_4bit.sv
// mac_accumulator_4bit: sums LEN consecutive 4x4 products into an ACC_W-bit
// result and hands it downstream over a valid/ready handshake.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operand-pair handshake for A, B
//   A, B                : unsigned 4-bit operands
//   out_valid/out_ready : result handshake
//   out_acc             : accumulated sum of LEN products
//   out_ovf             : sticky overflow flag for the current result
//   busy                : high while accumulating or holding a result
// Build option: define MAC_SATURATE_EN to clamp the sum at 2^ACC_W-1 on
// overflow instead of wrapping; the overflow flag is set either way.
module mac_accumulator_4bit
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned LEN   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(LEN + 1);
    // Count value in ACCUM whose accepted beat completes the result.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    mac_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum_wide;
    logic              carry;
    logic [ACC_W-1:0]  sum_next;
    logic              beat;

    multiplier_4bit u_mult (
        .A (A),
        .B (B),
        .P (prod)
    );

    assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(prod);
    assign carry    = sum_wide[ACC_W];

`ifdef MAC_SATURATE_EN
    // Once clamped, any further nonzero product carries again, so the
    // result stays pinned at full scale for the rest of the beats.
    assign sum_next = carry ? '1 : sum_wide[ACC_W-1:0];
`else
    assign sum_next = sum_wide[ACC_W-1:0];
`endif

    assign in_ready  = !rst && (state_q != HOLD);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    // First beat loads rather than adds, discarding the old result.
                    acc_d   = ACC_W'(prod);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = sum_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | carry;
                    if (cnt_q == LAST_CNT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// Testbench for mac_accumulator_4bit: three instances
//   dut0 ACC_W=16 LEN=4, dut1 ACC_W=8 LEN=4, dut2 ACC_W=16 LEN=1.
module tb_mac_accumulator_4bit;

    typedef struct {
        longint acc;
        bit     ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst       [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [3:0] A         [3];
    logic [3:0] B         [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic       out_ovf   [3];
    logic       busy      [3];
    logic [31:0] acc_x    [3];

    logic [15:0] out_acc0;
    logic [7:0]  out_acc1;
    logic [15:0] out_acc2;

    int checks = 0;
    int errors = 0;

    // Reference model: running true sum and beat count of the result in
    // progress, plus results completed but not yet taken downstream.
    longint part_sum [3];
    int     part_cnt [3];
    res_t   expq     [3][$];

    always #5 clk = ~clk;

    mac_accumulator_4bit #(.ACC_W(16), .LEN(4)) dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(A[0]), .B(B[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_acc(out_acc0), .out_ovf(out_ovf[0]), .busy(busy[0])
    );
    mac_accumulator_4bit #(.ACC_W(8), .LEN(4)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(A[1]), .B(B[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_acc(out_acc1), .out_ovf(out_ovf[1]), .busy(busy[1])
    );
    mac_accumulator_4bit #(.ACC_W(16), .LEN(1)) dut2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(A[2]), .B(B[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_acc(out_acc2), .out_ovf(out_ovf[2]), .busy(busy[2])
    );

    assign acc_x[0] = {16'b0, out_acc0};
    assign acc_x[1] = {24'b0, out_acc1};
    assign acc_x[2] = {16'b0, out_acc2};

    function automatic int accw(input int k);
        return (k == 1) ? 8 : 16;
    endfunction

    function automatic int lenk(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input int k, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d at %0t", name, k, got, exp, $time);
        end
    endtask

    task automatic model_accept(input int k, input int a, input int b);
        longint maxv;
        res_t   r;
        part_sum[k] += longint'(a * b);
        part_cnt[k]++;
        if (part_cnt[k] == lenk(k)) begin
            maxv  = (longint'(1) << accw(k)) - 1;
            r.ovf = (part_sum[k] > maxv);
`ifdef MAC_SATURATE_EN
            r.acc = r.ovf ? maxv : part_sum[k];
`else
            r.acc = part_sum[k] % (maxv + 1);
`endif
            expq[k].push_back(r);
            part_sum[k] = 0;
            part_cnt[k] = 0;
        end
    endtask

    // Monitor: every cycle, compare handshake signals against the model and
    // check/retire the held result.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                chk("in_ready_in_reset", k, in_ready[k], 0);
            end else begin
                bit hold;
                hold = (expq[k].size() != 0);
                chk("in_ready", k, in_ready[k], !hold);
                chk("out_valid", k, out_valid[k], hold);
                chk("busy", k, busy[k], hold || (part_cnt[k] != 0));
                if (hold && out_valid[k]) begin
                    chk("out_acc", k, acc_x[k], expq[k][0].acc);
                    chk("out_ovf", k, out_ovf[k], expq[k][0].ovf);
                    if (out_ready[k]) void'(expq[k].pop_front());
                end
            end
        end
    end

    // Offer one beat; called and returns at posedge+1.
    task automatic send(input int k, input int a, input int b, input int gap, input bit rnd_rdy);
        bit accepted;
        int n;
        repeat (gap) begin
            in_valid[k] = 1'b0;
            if (rnd_rdy) out_ready[k] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b1;
        A[k] = 4'(a);
        B[k] = 4'(b);
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 200) begin
            @(negedge clk);
            accepted = in_ready[k];
            @(posedge clk);
            if (accepted) model_accept(k, a, b);
            #1;
            n++;
            if (!accepted && rnd_rdy) out_ready[k] = 1'($urandom_range(0, 1));
        end
        in_valid[k] = 1'b0;
        if (!accepted) chk("accept_timeout", k, 0, 1);
    endtask

    task automatic drain(input int k);
        int n;
        out_ready[k] = 1'b1;
        n = 0;
        while (expq[k].size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", k, expq[k].size(), 0);
    endtask

    // Keep offering beats while a result is held with out_ready low.
    task automatic hold_cycles(input int k, input int n);
        repeat (n) begin
            in_valid[k] = 1'b1;
            A[k] = 4'($urandom_range(0, 15));
            B[k] = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic rst_pulse(input int k);
        rst[k] = 1'b1;
        in_valid[k] = 1'b0;
        @(posedge clk);
        part_sum[k] = 0;
        part_cnt[k] = 0;
        expq[k].delete();
        #1;
        rst[k] = 1'b0;
    endtask

    task automatic random_run(input int k, input int beats, input int lo);
        for (int i = 0; i < beats; i++) begin
            send(k, $urandom_range(lo, 15), $urandom_range(lo, 15), $urandom_range(0, 2), 1'b1);
        end
        drain(k);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
            A[k] = '0;
            B[k] = '0;
            part_sum[k] = 0;
            part_cnt[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_out_valid", k, out_valid[k], 0);
            chk("reset_out_acc", k, acc_x[k], 0);
            chk("reset_out_ovf", k, out_ovf[k], 0);
            chk("reset_busy", k, busy[k], 0);
            chk("reset_in_ready", k, in_ready[k], 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // Back-to-back beats, out_ready already high: 15+15+30+0 = 60.
        out_ready[0] = 1'b1;
        send(0, 3, 5, 0, 1'b0);
        send(0, 15, 1, 0, 1'b0);
        send(0, 10, 3, 0, 1'b0);
        send(0, 0, 15, 0, 1'b0);
        drain(0);

        // Gapped beats, result held five cycles with in_valid high.
        out_ready[0] = 1'b0;
        send(0, 3, 5, 1, 1'b0);
        send(0, 15, 1, 1, 1'b0);
        send(0, 10, 3, 1, 1'b0);
        send(0, 0, 15, 1, 1'b0);
        hold_cycles(0, 5);
        drain(0);

        // Partial sum discarded by reset; fresh result of 4.
        send(0, 15, 15, 0, 1'b0);
        send(0, 15, 15, 0, 1'b0);
        rst_pulse(0);
        for (int i = 0; i < 4; i++) send(0, 1, 1, 0, 1'b0);
        drain(0);

        // Consecutive results 16 then 12.
        for (int i = 0; i < 4; i++) send(0, 2, 2, 0, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 1, 3, 0, 1'b0);
        drain(0);

        random_run(0, 40, 0);

        // Narrow accumulator overflow: true sum 900.
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 15, 15, 0, 1'b0);
        drain(1);
        // Overflow result followed by a small one to confirm ovf clears.
        for (int i = 0; i < 4; i++) send(1, 15, 15, 0, 1'b0);
        for (int i = 0; i < 4; i++) send(1, 2, 3, 0, 1'b0);
        drain(1);
        random_run(1, 40, 6);

        // Single-beat results.
        out_ready[2] = 1'b1;
        send(2, 15, 15, 0, 1'b0);
        send(2, 7, 9, 0, 1'b0);
        drain(2);
        out_ready[2] = 1'b0;
        send(2, 4, 4, 0, 1'b0);
        hold_cycles(2, 3);
        drain(2);
        random_run(2, 20, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
